// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared states, opcodes and datapath select encodings for the multicycle controller
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, never on the state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp and instruction function fields to the ALU operation
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5] set) can request sub; addi ignores funct7b5.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM sequencing one RV32I instruction over the multicycle datapath
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       IllegalOp
);

    state_t     state_q, state_d;
    alu_op_t    alu_op;
    logic       pc_update, branch, ir_write, mem_write, reg_write, illegal;
    logic       adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = MemReady;
                pc_update  = MemReady;
                if (MemReady) state_d = DECODE;
            end
            DECODE: begin
                // Branch target PC+imm lands in ALUOut for BEQ to use.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECR;
                    OP_IALU:      state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                if (op == OP_LW)      state_d = MEMREAD;
                else if (op == OP_SW) state_d = MEMWRITE;
                else                  state_d = FETCH;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (MemReady) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (MemReady) state_d = FETCH;
            end
            EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                // PC takes the target held in ALUOut while the ALU forms OldPC+4 for the link.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

    // Every write enable is suppressed while reset is sampled so an abandoned instruction commits nothing.
    assign PCWrite   = ~reset & (pc_update | (branch & Zero));
    assign IRWrite   = ~reset & ir_write;
    assign MemWrite  = ~reset & mem_write;
    assign RegWrite  = ~reset & reg_write;
    assign IllegalOp = ~reset & illegal;
    assign AdrSrc    = adr_src;
    assign ResultSrc = result_src;
    assign ALUSrcA   = alu_src_a;
    assign ALUSrcB   = alu_src_b;
    assign ImmSrc    = imm_src_of(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_imm(input logic [6:0] o);
        if (o == T_SW)  return 1;
        if (o == T_BEQ) return 2;
        if (o == T_JAL) return 3;
        return 0;
    endfunction

    function automatic int exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o[5] && f7) ? 1 : 0;
            3'b010:  return 5;
            3'b110:  return 3;
            3'b111:  return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int cpi_of(input logic [6:0] o);
        if (o == T_LW) return 5;
        if (o == T_SW || o == T_R || o == T_I || o == T_JAL) return 4;
        if (o == T_BEQ) return 3;
        return 2;
    endfunction

    function automatic bit writes_reg(input logic [6:0] o);
        return (o == T_LW || o == T_R || o == T_I || o == T_JAL);
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return (o == T_LW || o == T_SW || o == T_R || o == T_I || o == T_BEQ || o == T_JAL);
    endfunction

    // Walk one instruction step by step; memory steps repeat until MemReady is seen high.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input bit rnd, input int data_stalls);
        int  steps, stalls_left, cyc;
        int  rw_seen, mw_seen, pcw_seen, ill_seen, mw_exp;
        bit  mem_step, done;
        logic mr;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        steps = cpi_of(o);
        stalls_left = data_stalls;
        cyc = 0; rw_seen = 0; mw_seen = 0; pcw_seen = 0; ill_seen = 0; mw_exp = 0;
        for (int s = 0; s < steps; s++) begin
            mem_step = (s == 0) || (s == 3 && (o == T_LW || o == T_SW));
            done = 1'b0;
            while (!done) begin
                if (!mem_step)                 mr = rnd ? 1'($urandom % 2) : 1'b1;
                else if (s > 0 && stalls_left > 0) begin
                    mr = 1'b0;
                    stalls_left--;
                end
                else                           mr = rnd ? 1'($urandom % 3 != 0) : 1'b1;
                MemReady = mr;
                #4;
                check("imm_src", ImmSrc, exp_imm(o));
                if (s == 0) begin
                    check("fetch_irwrite", IRWrite, mr);
                    check("fetch_pcwrite", PCWrite, mr);
                    check("fetch_adrsrc", AdrSrc, 0);
                    check("fetch_srca", ALUSrcA, 0);
                    check("fetch_srcb", ALUSrcB, 2);
                    check("fetch_result", ResultSrc, 2);
                    check("fetch_alu", ALUControl, 0);
                end else if (s == 1) begin
                    check("dec_illegal", IllegalOp, !is_legal(o));
                    check("dec_srca", ALUSrcA, 1);
                    check("dec_srcb", ALUSrcB, 1);
                    check("dec_alu", ALUControl, 0);
                end else if (s == 2) begin
                    if (o == T_R || o == T_I) begin
                        check("exec_alu", ALUControl, exp_alu(o, f3, f7));
                        check("exec_srca", ALUSrcA, 2);
                        check("exec_srcb", ALUSrcB, (o == T_R) ? 0 : 1);
                    end else if (o == T_BEQ) begin
                        check("beq_alu", ALUControl, 1);
                        check("beq_pcwrite", PCWrite, z);
                        check("beq_srcb", ALUSrcB, 0);
                    end else if (o == T_JAL) begin
                        check("jal_pcwrite", PCWrite, 1);
                        check("jal_srca", ALUSrcA, 1);
                        check("jal_srcb", ALUSrcB, 2);
                    end else begin
                        check("memadr_alu", ALUControl, 0);
                        check("memadr_srca", ALUSrcA, 2);
                    end
                end else if (s == 3 && (o == T_LW || o == T_SW)) begin
                    check("mem_adrsrc", AdrSrc, 1);
                    check("mem_memwrite", MemWrite, o == T_SW);
                    if (o == T_SW) mw_exp++;
                end
                if (s == steps - 1 && writes_reg(o)) begin
                    check("wb_regwrite", RegWrite, 1);
                    check("wb_result", ResultSrc, (o == T_LW) ? 1 : 0);
                end
                rw_seen  += int'(RegWrite);
                mw_seen  += int'(MemWrite);
                pcw_seen += int'(PCWrite);
                ill_seen += int'(IllegalOp);
                @(posedge clk);
                #1;
                cyc++;
                done = !mem_step || mr;
                if (cyc > 64) begin
                    check("instr_timeout", cyc, 64);
                    return;
                end
            end
        end
        check("regwrite_count", rw_seen, writes_reg(o));
        check("memwrite_count", mw_seen, mw_exp);
        check("pcwrite_count", pcw_seen, 1 + int'(o == T_JAL) + int'(o == T_BEQ && z));
        check("illegal_count", ill_seen, !is_legal(o));
    endtask

    logic [6:0] ops [7];
    logic [6:0] bad_ops [5];
    logic [2:0] f3s [6];

    initial begin
        ops     = '{T_R, T_I, T_LW, T_SW, T_BEQ, T_JAL, 7'b0000000};
        bad_ops = '{7'b0000000, 7'b0110111, 7'b1100111, 7'b0010111, 7'b1111111};
        f3s     = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b001, 3'b100};

        reset = 1'b1; MemReady = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
        @(posedge clk); #1;
        #4;
        check("rst_pcwrite", PCWrite, 0);
        check("rst_irwrite", IRWrite, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_illegal", IllegalOp, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #4;
        check("post_rst_adrsrc", AdrSrc, 0);
        check("post_rst_srca", ALUSrcA, 0);
        check("post_rst_srcb", ALUSrcB, 2);
        check("post_rst_result", ResultSrc, 2);
        check("post_rst_alu", ALUControl, 0);
        check("post_rst_pcwrite", PCWrite, 1);
        check("post_rst_irwrite", IRWrite, 1);
        check("post_rst_regwrite", RegWrite, 0);
        MemReady = 1'b0;
        #1;
        check("post_rst_pcwrite_stall", PCWrite, 0);
        check("post_rst_irwrite_stall", IRWrite, 0);
        @(posedge clk); #1;

        run_instr(T_R, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        run_instr(T_LW, 3'b010, 1'b0, 1'b0, 1'b0, 2);
        run_instr(T_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1);
        run_instr(T_BEQ, 3'b000, 1'b0, 1'b1, 1'b0, 0);
        run_instr(T_BEQ, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        run_instr(T_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        run_instr(T_R, 3'b000, 1'b1, 1'b0, 1'b0, 0);
        run_instr(T_I, 3'b000, 1'b1, 1'b0, 1'b0, 0);

        // Reset lands while a store waits on memory.
        op = T_SW; funct3 = 3'b010; funct7b5 = 1'b0; MemReady = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        MemReady = 1'b0;
        #4;
        check("memwrite_before_rst", MemWrite, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_memwrite", MemWrite, 0);
        check("rst_mid_pcwrite", PCWrite, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        MemReady = 1'b0;
        #4;
        check("after_rst_result", ResultSrc, 2);
        check("after_rst_adrsrc", AdrSrc, 0);
        check("after_rst_memwrite", MemWrite, 0);
        check("after_rst_irwrite", IRWrite, 0);
        @(posedge clk); #1;
        run_instr(T_SW, 3'b010, 1'b0, 1'b0, 1'b0, 0);

        for (int k = 0; k < 200; k++) begin
            logic [6:0] o;
            o = ops[$urandom % 7];
            if (o == 7'b0000000) o = bad_ops[$urandom % 5];
            run_instr(o, f3s[$urandom % 6], 1'($urandom % 2), 1'($urandom % 2), 1'b1,
                      int'($urandom % 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
